// File: rtl/seven_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed driver for a 3-digit 7-segment display. The three BCD
// digits are latched once per scan frame (on the slot-2 -> slot-0 tick) so a
// frame never shows a mix of old and new digits. Each digit slot lasts
// REFRESH_DIV clocks; the first GUARD clocks of every slot keep all digit
// enables off to suppress ghosting. Optional leading-zero blanking.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   GUARD        enable-off cycles at the start of each slot (< REFRESH_DIV)
//   ACTIVE_LOW   1: seg/an inverted at the pins (common anode), 0: active-high
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   digit0       units BCD digit
//   digit1       tens BCD digit
//   digit2       hundreds BCD digit
//   blank_lz     1 = blank leading zeros
//   seg          segments, seg[0]=a ... seg[6]=g
//   an           digit enables, an[i] drives digit i
//   frame_start  one-cycle pulse after a new frame is latched
// ----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int GRD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(1);

    // Logical segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] i);
        one_hot = 3'b001 << i;
    endfunction

    logic [CNT_W-1:0] prescale;
    logic [1:0]       idx;
    logic [GRD_W-1:0] guard_cnt;
    // Only tens and hundreds are kept: the units digit is decoded on the very
    // edge that latches the frame, so the live input is the snapshot value.
    logic [3:0]       snap1;
    logic [3:0]       snap2;
    logic [6:0]       seg_q;
    logic [2:0]       an_q;
    logic             slot_blank;

    logic             tick;
    logic             new_frame;
    logic [1:0]       next_idx;
    logic [3:0]       sel_digit;
    logic             sel_blank;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        tick      = (prescale == CNT_MAX);
        next_idx  = 2'd0;
        sel_digit = digit0;
        sel_blank = 1'b0;

        if (idx == 2'd0)      next_idx = 2'd1;
        else if (idx == 2'd1) next_idx = 2'd2;

        new_frame = tick && (idx == 2'd2);

        case (next_idx)
            2'd1: begin
                sel_digit = snap1;
                sel_blank = blank_lz && (snap2 == 4'd0) && (snap1 == 4'd0);
            end
            2'd2: begin
                sel_digit = snap2;
                sel_blank = blank_lz && (snap2 == 4'd0);
            end
            default: begin
                sel_digit = digit0;
                sel_blank = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale    <= '0;
            idx         <= 2'd2;
            guard_cnt   <= '0;
            snap1       <= 4'd0;
            snap2       <= 4'd0;
            seg_q       <= 7'h00;
            an_q        <= 3'b000;
            slot_blank  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            prescale    <= tick ? '0 : prescale + 1'b1;
            frame_start <= new_frame;

            if (new_frame) begin
                snap1 <= digit1;
                snap2 <= digit2;
            end

            if (tick) begin
                idx        <= next_idx;
                seg_q      <= sel_blank ? 7'h00 : decode(sel_digit);
                slot_blank <= sel_blank;
                guard_cnt  <= GRD_LOAD;
                // With no guard interval the enable comes on with the new slot.
                an_q       <= (GUARD == 0 && !sel_blank) ? one_hot(next_idx) : 3'b000;
            end else if (guard_cnt != '0) begin
                guard_cnt <= guard_cnt - 1'b1;
                // Enable on the edge the counter reaches zero: exactly GUARD
                // off-cycles after the tick.
                if (guard_cnt == GRD_LAST && !slot_blank) begin
                    an_q <= one_hot(idx);
                end
            end
        end
    end

    assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
    assign an  = ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Self-checking bench for seven_seg_scan_driver with REFRESH_DIV=8, GUARD=2,
// ACTIVE_LOW=1. The reference model works from the edge count since reset
// release: slot k (k >= 1) starts on edge 8k, shows digit (k-1) mod 3, and
// the frame digits are captured whenever a slot-0 period begins.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int RD = 8;
    localparam int GD = 2;
    localparam bit AL = 1'b1;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] d0, d1, d2;
    logic       blz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       fs;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int       n_edges = 0;
    int       fd [3];
    bit       m_blank;
    logic [6:0] m_seg;

    seven_seg_scan_driver #(
        .REFRESH_DIV (RD),
        .GUARD       (GD),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit0      (d0),
        .digit1      (d1),
        .digit2      (d2),
        .blank_lz    (blz),
        .seg         (seg),
        .an          (an),
        .frame_start (fs)
    );

    always #5 if (clk_en) clk = ~clk;

    function automatic logic [6:0] ref_decode(input int v);
        if (v > 9) return 7'h40;
        return SEG_TAB[v];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n_edges);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        check({tag, "_an"},  {5'b0, an},  8'h07);
        check({tag, "_fs"},  {7'b0, fs},  8'h00);
    endtask

    task automatic model_reset();
        n_edges = 0;
        m_seg   = 7'h00;
        m_blank = 1'b0;
        for (int i = 0; i < 3; i++) fd[i] = 0;
    endtask

    // One clock: advance the model on the edge, then compare 1 time unit later.
    task automatic step();
        logic [6:0] e_seg;
        logic [2:0] e_an;
        logic       e_fs;
        int k, s, off;
        @(posedge clk);
        n_edges++;
        e_seg = 7'h00;
        e_an  = 3'b000;
        e_fs  = 1'b0;
        if (n_edges >= RD) begin
            k   = n_edges / RD;
            s   = (k - 1) % 3;
            off = n_edges % RD;
            if (off == 0) begin
                if (s == 0) begin
                    fd[0] = int'(d0);
                    fd[1] = int'(d1);
                    fd[2] = int'(d2);
                end
                m_blank = blz && ((s == 2 && fd[2] == 0) ||
                                  (s == 1 && fd[2] == 0 && fd[1] == 0));
                m_seg   = m_blank ? 7'h00 : ref_decode(fd[s]);
            end
            e_seg = m_seg;
            e_an  = (off < GD || m_blank) ? 3'b000 : 3'(1 << s);
            e_fs  = (off == 0 && s == 0);
        end
        #1;
        check("seg", {1'b0, seg}, {1'b0, AL ? ~e_seg : e_seg});
        check("an",  {5'b0, an},  {5'b0, AL ? ~e_an : e_an});
        check("frame_start", {7'b0, fs}, {7'b0, e_fs});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        d0 = 4'd0; d1 = 4'd1; d2 = 4'd0; blz = 1'b1;

        // Reset with no clock running.
        #2 rst = 1'b1;
        #1 check_off("reset_noclk");

        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Value 10 with blanking: 40/6, 79/5, blanked slot 2; guard on every slot.
        run(3 * 3 * RD);

        // Snapshot: units 3 latched, changed to 7 during slot 1.
        d1 = 4'd0; d0 = 4'd3; blz = 1'b0;
        run(RD + RD + 3);
        d0 = 4'd7;
        d2 = 4'd6;
        run(3 * RD + RD);

        // Dash on the units digit, then 0/0/0 without blanking.
        d0 = 4'hC; d1 = 4'd0; d2 = 4'd0;
        run(3 * RD);
        d0 = 4'd0;
        run(2 * 3 * RD);

        // 0/0/0 with blanking: only the units digit lights.
        blz = 1'b1;
        run(3 * RD);

        // Randomised inputs, changed at arbitrary points in the frame.
        for (int i = 0; i < 480; i++) begin
            step();
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(2))
                    0: d0 = 4'($urandom_range(15));
                    1: d1 = 4'($urandom_range(9) == 0 ? 0 : $urandom_range(15));
                    default: d2 = 4'($urandom_range(3) == 0 ? 0 : $urandom_range(15));
                endcase
            end
            if ($urandom_range(15) == 0) blz = 1'($urandom_range(1));
        end

        // Reset mid-scan, in the slot-1 guard interval.
        d2 = 4'd5; d1 = 4'd8; d0 = 4'd2; blz = 1'b0;
        run(3 * RD);
        for (int i = 0; i < 3 * RD && (n_edges % (3 * RD)) != 2 * RD; i++) step();
        check("pre_reset_seg", {1'b0, seg}, 8'h00);
        #1 rst = 1'b1;
        #1 check_off("reset_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check_off("reset_held");
        end
        d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(3 * 3 * RD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
